pipe_drain_fifo: RTL
====================

PIPE_DRAIN_FIFO -- requirements
Module: pipe_drain_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32: payload width; matches the 32-bit adder pipeline result.
REQ-002 SHALL have parameter DEPTH, default 4: entry count; a power of two, >= 2.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port issue, input, 1: the upstream pipeline launches one operation this cycle; this is the pipeline's in_valid.
REQ-006 SHALL have port can_issue, output, 1: the upstream may assert issue this cycle.
REQ-007 SHALL have port in_data, input, DATA_W: the result from the pipeline's final register.
REQ-008 SHALL have port in_valid, input, 1: in_data is valid; this is the pipeline's out_valid; there is no backpressure on it.
REQ-009 SHALL have port out_data, output, DATA_W: the head entry.
REQ-010 SHALL have port out_valid, output, 1: the head entry is valid.
REQ-011 SHALL have port out_ready, input, 1: the consumer accepts the head entry.
REQ-012 SHALL have port level, output, $clog2(DEPTH+1): the stored entry count.
REQ-013 SHALL have port overflow, output, 1: sticky protocol-violation flag.

Function
REQ-014 SHALL hold occupancy O (0..DEPTH) and reservation count R (0..DEPTH), both registered.
REQ-015 SHALL drive can_issue = (O + R) < DEPTH, decoded only from registers with no path from any input.
REQ-016 SHALL increment R on issue while can_issue is 1.
REQ-017 SHALL decrement R on in_valid while R > 0.
REQ-018 SHALL leave R unchanged when issue and in_valid are accepted in the same cycle.
REQ-019 SHALL define push = in_valid and (O < DEPTH or pop), and pop = out_valid and out_ready.
REQ-020 SHALL write in_data at wr_ptr on push.
REQ-021 SHALL advance rd_ptr on pop.
REQ-022 SHALL wrap both pointers modulo DEPTH.
REQ-023 SHALL update O as O + push - pop.
REQ-024 SHALL be first-word fall-through: out_valid = (O != 0); out_data = mem[rd_ptr], combinational from storage.
REQ-025 SHALL show data on out_valid/out_data exactly one cycle after in_valid when the FIFO was empty: 1-cycle latency.
REQ-026 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-027 SHALL accept push and pop in the same cycle at O=DEPTH; O stays DEPTH.
REQ-028 SHALL accept push and pop in the same cycle at O=0 only when out_valid was already 1; otherwise no pop.
REQ-029 SHALL ignore issue while can_issue is 0: R unchanged.
REQ-030 SHALL drop in_valid data when O=DEPTH with no pop: storage unchanged.
REQ-031 SHALL leave R unchanged for in_valid with R=0: unreserved arrival, stored if space.
REQ-032 SHALL equal level to O.

Reset
REQ-033 SHALL on rst_n=0 at a clock edge set O=0, R=0, wr_ptr=0, rd_ptr=0, overflow=0.
REQ-034 SHALL give reset priority over issue, in_valid and out_ready in the same cycle.
REQ-035 SHALL need no storage-array reset; out_data is don't-care while out_valid=0.
REQ-036 SHALL drive out_valid=0, can_issue=1 and level=0 in the cycle after reset.
REQ-037 SHALL discard in-flight reservations on mid-operation reset; later in_valid is treated as unreserved (REQ-031).

Configuration
REQ-038 SHALL, with PIPE_DRAIN_FIFO_OVERFLOW_EN defined, set overflow to 1 on issue while can_issue=0, on a dropped in_valid, or on in_valid with R=0; overflow holds until reset.
REQ-039 SHALL, without the macro, drive overflow constant 0 with no flag register; drop and ignore behaviour is unchanged.

Structure
REQ-040 SHALL define the DATA_W default, the DEPTH default and the pointer/count width constants in shared package pipe_drain_pkg.
REQ-041 SHALL place the storage in sub-module pipe_drain_ram: DEPTH x DATA_W, one synchronous write port, one combinational read port.
REQ-042 SHALL keep pointer, count and flag logic in pipe_drain_fifo.

Verification (DATA_W=32, DEPTH=4)
REQ-043 SHALL cover: reset, then issue with 0x5 arriving 2 cycles later, out_ready=1 -> out_data=0x5 and out_valid=1 one cycle after in_valid; level back to 0 after pop.
REQ-044 SHALL cover: four issues with out_ready=0 -> can_issue falls to 0 after the 4th issue; a 5th issue is ignored; overflow=1 (macro on) or 0 (macro off).
REQ-045 SHALL cover: fill with 0x1..0x4, then out_ready=1 with simultaneous in_valid 0x5 -> level stays 4; output order 1,2,3,4,5.
REQ-046 SHALL cover: in_valid with R=0 at level=4, out_ready=0 -> data dropped, level=4, overflow=1 (macro on).
REQ-047 SHALL cover: rst_n=0 for one cycle with level=3 and R=1 -> next cycle out_valid=0, level=0, can_issue=1, overflow=0.
REQ-048 SHALL cover: 1000 random issue/out_ready cycles obeying can_issue -> no overflow, in-order data match against a scoreboard, O+R <= 4 always.

Source files
------------

// File: rtl/pipe_drain_pkg.sv
// Shared defaults and width helpers for the pipeline drain FIFO.
package pipe_drain_pkg;

    localparam int PD_DATA_W = 32;
    localparam int PD_DEPTH  = 4;

    function automatic int pd_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int pd_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int PD_PTR_W = pd_ptr_w(PD_DEPTH);
    localparam int PD_CNT_W = pd_cnt_w(PD_DEPTH);

endpackage

// File: rtl/pipe_drain_ram.sv
// Storage array: one synchronous write port, one combinational read port.
module pipe_drain_ram
    import pipe_drain_pkg::*;
#(
    parameter int DATA_W = PD_DATA_W,
    parameter int DEPTH  = PD_DEPTH,
    parameter int PTR_W  = pd_ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [PTR_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [PTR_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipe_drain_fifo.sv
// Reservation-based drain FIFO behind a fixed-latency pipeline.
// Define PIPE_DRAIN_FIFO_OVERFLOW_EN to build the sticky overflow flag.
module pipe_drain_fifo
    import pipe_drain_pkg::*;
#(
    parameter int DATA_W = PD_DATA_W,
    parameter int DEPTH  = PD_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue,
    output logic                         can_issue,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow
);

    localparam int PTR_W = pd_ptr_w(DEPTH);
    localparam int CNT_W = pd_cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_S = (CNT_W+1)'(DEPTH);

    logic [CNT_W-1:0] r_occ;
    logic [CNT_W-1:0] r_res;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;

    logic [CNT_W:0] w_sum;
    logic           w_pop;
    logic           w_push;
    logic           w_iss;
    logic           w_rdec;

    // Reservations count as occupied so in-flight results always land.
    assign w_sum     = {1'b0, r_occ} + {1'b0, r_res};
    assign can_issue = w_sum < DEPTH_S;
    assign out_valid = r_occ != '0;
    assign level     = r_occ;

    assign w_pop  = out_valid & out_ready;
    assign w_push = in_valid & ((r_occ != DEPTH_C) | w_pop);
    assign w_iss  = issue & can_issue;
    assign w_rdec = in_valid & (r_res != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ    <= '0;
            r_res    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            unique case ({w_iss, w_rdec})
                2'b10:   r_res <= r_res + 1'b1;
                2'b01:   r_res <= r_res - 1'b1;
                default: r_res <= r_res;
            endcase
        end
    end

`ifdef PIPE_DRAIN_FIFO_OVERFLOW_EN
    logic r_ovf;
    logic w_viol;

    assign w_viol = (issue & ~can_issue)
                  | (in_valid & ~w_push)
                  | (in_valid & (r_res == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_viol) begin
            r_ovf <= 1'b1;
        end
    end

    assign overflow = r_ovf;
`else
    assign overflow = 1'b0;
`endif

    pipe_drain_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (out_data)
    );

endmodule
